// File: rtl/seq_detect_param.sv
// Serial pattern detector with a runtime-loadable pattern, overlapping or
// non-overlapping detection, and a saturating match counter.
module seq_detect_param #(
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1001,
    parameter int             CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ip,
    input  logic                     en,
    input  logic                     overlap,
    input  logic                     load,
    input  logic [LEN-1:0]           pat_in,
    input  logic                     clr_cnt,
    output logic                     op,
    output logic [CNT_W-1:0]         match_cnt,
    output logic [$clog2(LEN)-1:0]   fill
);

    localparam int                FW       = $clog2(LEN);
    localparam logic [FW-1:0]     FILL_MAX = FW'(LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    logic [LEN-1:0] pat;
    logic [LEN-2:0] hist;
    logic [LEN-1:0] window;
    logic           match;

    // The incoming bit completes the window; only a full history may match.
    assign window = {hist, ip};
    assign match  = en && !load && (fill == FILL_MAX) && (window == pat);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op        <= 1'b0;
            match_cnt <= '0;
            fill      <= '0;
            hist      <= '0;
            pat       <= PATTERN;
        end else begin
            op <= match;

            if (match) begin
                if (clr_cnt)
                    match_cnt <= CNT_W'(1);
                else if (match_cnt != CNT_MAX)
                    match_cnt <= match_cnt + CNT_W'(1);
            end else if (clr_cnt) begin
                match_cnt <= '0;
            end

            // A load restarts detection and wins over a sample on the same edge.
            if (load) begin
                pat  <= pat_in;
                fill <= '0;
            end else if (en) begin
                hist <= window[LEN-2:0];
                if (match && !overlap)
                    fill <= '0;
                else if (fill != FILL_MAX)
                    fill <= fill + FW'(1);
            end
        end
    end

endmodule
